// File: rtl/simd_mac_accumulator.sv
// rtl/simd_mac_accumulator.sv - SIMD lane-partitioned multiply-accumulate frame accumulator
//
// Merges the two multiplier output rows per lane, accumulates the merged lanes
// over a framed sequence of beats and presents the frame total.
//
// Ports:
//   clk, reset                 clock (rising edge), synchronous active-high reset
//   in_valid/in_ready          beat handshake
//   in_first/in_last           frame delimiters of the beat
//   mode                       00 = 1x32, 01 = 2x16, 10 = 4x8, 11 = reserved
//   in_signed                  lane products are signed
//   result_0/result_1          multiplier rows to be merged
//   out_valid/out_ready        frame result handshake
//   out_acc                    lane-partitioned 64-bit total
//   out_mode                   mode of the frame
//   out_ovf                    sticky per-lane overflow
//   out_err                    frame protocol error
//   out_count                  number of beats accumulated
module simd_mac_accumulator #(
    parameter int SATURATE = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [1:0]       mode,
    input  logic             in_signed,
    input  logic [31:0]      result_0,
    input  logic [31:0]      result_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_acc,
    output logic [1:0]       out_mode,
    output logic [3:0]       out_ovf,
    output logic             out_err,
    output logic [CNT_W-1:0] out_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             en;
    logic             reset_q;
    logic             accept;
    logic [31:0]      in_sum;

    logic             s1_valid;
    logic [31:0]      s1_p;
    logic             s1_first;
    logic             s1_last;
    logic             s1_signed;
    logic [1:0]       s1_mode;

    logic             frame_open;
    logic [1:0]       lat_mode;
    logic [63:0]      acc;
    logic [3:0]       ovf_q;
    logic             err_q;
    logic [CNT_W-1:0] cnt_q;

    logic             is_first;
    logic             bad_beat;
    logic [63:0]      acc_nxt;
    logic [3:0]       lane_ovf;
    logic [63:0]      f_acc;
    logic [3:0]       f_ovf;
    logic             f_err;
    logic [CNT_W-1:0] f_cnt;
    logic [1:0]       f_mode;

    // A stalled output register freezes every stage, so nothing can be overwritten.
    assign en       = !out_valid || out_ready;
    // reset_q keeps in_ready low on the first cycle after reset is released.
    assign in_ready = en && !reset && !reset_q;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        reset_q <= reset;
    end

    // Row merge with carries broken at the lane boundaries of the selected mode.
    always_comb begin
        in_sum = result_0 + result_1;
        case (mode)
            2'b01: begin
                in_sum[15:0]  = result_0[15:0] + result_1[15:0];
                in_sum[31:16] = result_0[31:16] + result_1[31:16];
            end
            2'b10: begin
                in_sum[7:0]   = result_0[7:0] + result_1[7:0];
                in_sum[15:8]  = result_0[15:8] + result_1[15:8];
                in_sum[23:16] = result_0[23:16] + result_1[23:16];
                in_sum[31:24] = result_0[31:24] + result_1[31:24];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid  <= 1'b0;
            s1_p      <= '0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_signed <= 1'b0;
            s1_mode   <= 2'b00;
        end else if (en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_p      <= in_sum;
                s1_first  <= in_first;
                s1_last   <= in_last;
                s1_signed <= in_signed;
                s1_mode   <= mode;
            end
        end
    end

    // An orphan non-first beat restarts the frame as if it were first.
    assign is_first = s1_first || !frame_open;
    assign bad_beat = (s1_mode == 2'b11) || (!is_first && (s1_mode != lat_mode));

    // Per-lane extend/add/overflow/clamp. A first beat adds onto zero, which never overflows.
    always_comb begin
        logic [63:0] base;
        logic [63:0] e64;
        logic [64:0] s65;
        logic [31:0] b32, e32;
        logic [32:0] s33;
        logic [15:0] b16, e16;
        logic [16:0] s17;
        logic        o;

        base     = is_first ? 64'd0 : acc;
        acc_nxt  = '0;
        lane_ovf = '0;
        e64 = '0; s65 = '0; b32 = '0; e32 = '0; s33 = '0;
        b16 = '0; e16 = '0; s17 = '0; o = 1'b0;

        case (s1_mode)
            2'b01: begin
                for (int i = 0; i < 2; i++) begin
                    b32 = base[32*i +: 32];
                    e32 = {{16{s1_signed & s1_p[16*i+15]}}, s1_p[16*i +: 16]};
                    s33 = {1'b0, b32} + {1'b0, e32};
                    o   = s1_signed ? ((b32[31] == e32[31]) && (s33[31] != b32[31])) : s33[32];
                    acc_nxt[32*i +: 32] = s33[31:0];
                    if (o && (SATURATE != 0))
                        acc_nxt[32*i +: 32] = s1_signed ? (b32[31] ? 32'h8000_0000 : 32'h7FFF_FFFF)
                                                        : 32'hFFFF_FFFF;
                    lane_ovf[i] = o;
                end
            end
            2'b10: begin
                for (int i = 0; i < 4; i++) begin
                    b16 = base[16*i +: 16];
                    e16 = {{8{s1_signed & s1_p[8*i+7]}}, s1_p[8*i +: 8]};
                    s17 = {1'b0, b16} + {1'b0, e16};
                    o   = s1_signed ? ((b16[15] == e16[15]) && (s17[15] != b16[15])) : s17[16];
                    acc_nxt[16*i +: 16] = s17[15:0];
                    if (o && (SATURATE != 0))
                        acc_nxt[16*i +: 16] = s1_signed ? (b16[15] ? 16'h8000 : 16'h7FFF) : 16'hFFFF;
                    lane_ovf[i] = o;
                end
            end
            default: begin
                e64 = {{32{s1_signed & s1_p[31]}}, s1_p};
                s65 = {1'b0, base} + {1'b0, e64};
                o   = s1_signed ? ((base[63] == e64[63]) && (s65[63] != base[63])) : s65[64];
                acc_nxt = s65[63:0];
                if (o && (SATURATE != 0))
                    acc_nxt = s1_signed ? (base[63] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF)
                                        : 64'hFFFF_FFFF_FFFF_FFFF;
                lane_ovf[0] = o;
            end
        endcase
    end

    // Frame state after the S1 beat is applied; also feeds the output register on a last beat.
    always_comb begin
        f_acc  = is_first ? 64'd0 : acc;
        f_ovf  = is_first ? 4'd0 : ovf_q;
        f_err  = is_first ? 1'b0 : err_q;
        f_cnt  = is_first ? '0 : cnt_q;
        f_mode = is_first ? s1_mode : lat_mode;
        if (!s1_first && !frame_open)
            f_err = 1'b1;
        if (bad_beat) begin
            f_err = 1'b1;
        end else begin
            f_acc = acc_nxt;
            f_ovf = f_ovf | lane_ovf;
            if (is_first)
                f_cnt = CNT_ONE;
            else if (cnt_q != CNT_MAX)
                f_cnt = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_open <= 1'b0;
            lat_mode   <= 2'b00;
            acc        <= '0;
            ovf_q      <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
            out_valid  <= 1'b0;
            out_acc    <= '0;
            out_mode   <= 2'b00;
            out_ovf    <= '0;
            out_err    <= 1'b0;
            out_count  <= '0;
        end else if (en) begin
            out_valid <= s1_valid && s1_last;
            if (s1_valid) begin
                frame_open <= !s1_last;
                lat_mode   <= f_mode;
                acc        <= f_acc;
                ovf_q      <= f_ovf;
                err_q      <= f_err;
                cnt_q      <= f_cnt;
                if (s1_last) begin
                    out_acc   <= f_acc;
                    out_mode  <= f_mode;
                    out_ovf   <= f_ovf;
                    out_err   <= f_err;
                    out_count <= f_cnt;
                end
            end
        end
    end

endmodule

// File: tb/tb_simd_mac_accumulator.sv
// tb/tb_simd_mac_accumulator.sv - self-checking bench for simd_mac_accumulator
module tb_simd_mac_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_first = 1'b0;
    logic        in_last = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        in_signed = 1'b0;
    logic [31:0] result_0 = '0;
    logic [31:0] result_1 = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_acc;
    logic [1:0]  out_mode;
    logic [3:0]  out_ovf;
    logic        out_err;
    logic [7:0]  out_count;

    simd_mac_accumulator #(.SATURATE(1), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_first(in_first), .in_last(in_last),
        .mode(mode), .in_signed(in_signed),
        .result_0(result_0), .result_1(result_1),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_acc(out_acc), .out_mode(out_mode), .out_ovf(out_ovf),
        .out_err(out_err), .out_count(out_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: lanes handled as plain numbers with range checks.
    typedef struct {
        logic [63:0] acc;
        logic [1:0]  mode;
        logic [3:0]  ovf;
        logic        err;
        logic [7:0]  cnt;
    } res_t;

    res_t        exp_q[$];
    logic        m_open = 1'b0;
    logic [1:0]  m_mode = 2'b00;
    logic [63:0] m_acc = '0;
    logic [3:0]  m_ovf = '0;
    logic        m_err = 1'b0;
    int          m_cnt = 0;

    task automatic model_beat(input logic f, input logic l, input logic [1:0] md, input logic sg,
                              input logic [31:0] a, input logic [31:0] b);
        logic bad, first;
        int n, pw, aw;
        logic [71:0] mask_p, mask_a, pa, pb, ps, cur, tmp;
        logic signed [71:0] pv, cv, nv, lo, hi;
        res_t r;
        first = f || !m_open;
        bad = (md == 2'b11) || (!first && md != m_mode);
        if (first) begin
            m_err  = !f;
            m_open = 1'b1;
            m_mode = md;
            m_ovf  = '0;
            m_cnt  = 0;
            m_acc  = '0;
        end
        if (bad) begin
            m_err = 1'b1;
        end else begin
            n  = (md == 2'b00) ? 1 : (md == 2'b01) ? 2 : 4;
            pw = 32 / n;
            aw = 64 / n;
            mask_p = (72'd1 << pw) - 72'd1;
            mask_a = (72'd1 << aw) - 72'd1;
            for (int i = 0; i < n; i++) begin
                pa = (72'(a) >> (i * pw)) & mask_p;
                pb = (72'(b) >> (i * pw)) & mask_p;
                ps = (pa + pb) & mask_p;
                pv = $signed(ps);
                if (sg && ps[pw-1]) pv = pv - (72'sd1 <<< pw);
                cur = (72'(m_acc) >> (i * aw)) & mask_a;
                cv = $signed(cur);
                if (sg && cur[aw-1]) cv = cv - (72'sd1 <<< aw);
                nv = first ? pv : cv + pv;
                if (sg) begin
                    lo = -(72'sd1 <<< (aw - 1));
                    hi = (72'sd1 <<< (aw - 1)) - 72'sd1;
                end else begin
                    lo = 72'sd0;
                    hi = (72'sd1 <<< aw) - 72'sd1;
                end
                if (nv > hi) begin m_ovf[i] = 1'b1; nv = hi; end
                else if (nv < lo) begin m_ovf[i] = 1'b1; nv = lo; end
                tmp = (72'(m_acc) & ~(mask_a << (i * aw))) | ((72'(nv) & mask_a) << (i * aw));
                m_acc = tmp[63:0];
            end
            m_cnt = first ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
        end
        if (l) begin
            r.acc = m_acc; r.mode = m_mode; r.ovf = m_ovf; r.err = m_err; r.cnt = 8'(m_cnt);
            exp_q.push_back(r);
            m_open = 1'b0;
        end
    endtask

    // Single compare process: results checked against the model at every output handshake.
    always @(negedge clk) begin
        res_t e;
        if (reset) begin
            m_open = 1'b0;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_errors++;
                    $display("FAIL unexpected_out: got out_acc 0x%0h with no frame pending", out_acc);
                end else begin
                    e = exp_q.pop_front();
                    chk("model_acc", out_acc, e.acc);
                    chk("model_mode", 64'(out_mode), 64'(e.mode));
                    chk("model_ovf", 64'(out_ovf), 64'(e.ovf));
                    chk("model_err", 64'(out_err), 64'(e.err));
                    chk("model_count", 64'(out_count), 64'(e.cnt));
                end
            end
            if (in_valid && in_ready)
                model_beat(in_first, in_last, mode, in_signed, result_0, result_1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic f, input logic l, input logic [1:0] md, input logic sg,
                             input logic [31:0] a, input logic [31:0] b);
        logic got;
        int k;
        in_valid = 1'b1; in_first = f; in_last = l; mode = md; in_signed = sg;
        result_0 = a; result_1 = b;
        got = 1'b0;
        k = 0;
        while (!got && k < 50) begin
            @(negedge clk);
            got = in_ready;
            tick();
            k++;
        end
        if (!got) begin
            n_checks++; n_errors++;
            $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", k);
        end
        in_valid = 1'b0;
    endtask

    task automatic expect_out(input string name, input logic [63:0] a, input logic [1:0] md,
                              input logic [3:0] ov, input logic er, input logic [7:0] cn);
        chk({name, "_valid"}, 64'(out_valid), 64'd1);
        chk({name, "_acc"}, out_acc, a);
        chk({name, "_mode"}, 64'(out_mode), 64'(md));
        chk({name, "_ovf"}, 64'(out_ovf), 64'(ov));
        chk({name, "_err"}, 64'(out_err), 64'(er));
        chk({name, "_count"}, 64'(out_count), 64'(cn));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_acc", out_acc, 64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_ovf_err", {59'd0, out_ovf, out_err}, 64'd0);
        reset = 1'b0;
        chk("post_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("ready_after_rst", 64'(in_ready), 64'd1);

        // Single-beat mode 00 frame, latency check
        send_beat(1, 1, 2'b00, 0, 32'h0000_1000, 32'h0000_0234);
        chk("lat_not_yet", 64'(out_valid), 64'd0);
        tick();
        expect_out("t1", 64'h1234, 2'b00, 4'd0, 1'b0, 8'd1);
        tick();

        // Mode 10 signed, 3 beats, followed immediately by the next frame
        for (int i = 0; i < 3; i++)
            send_beat(i == 0, i == 2, 2'b10, 1, 32'h0101_017F, 32'h0);
        tick();
        expect_out("m10", 64'h0003_0003_0003_017D, 2'b10, 4'd0, 1'b0, 8'd3);

        // Mode 01 signed sign extension of 0x8000 lanes
        send_beat(1, 0, 2'b01, 1, 32'h8000_0000, 32'h0);
        send_beat(0, 1, 2'b01, 1, 32'h8000_0000, 32'h0);
        tick();
        expect_out("m01s", 64'hFFFF_0000_0000_0000, 2'b01, 4'd0, 1'b0, 8'd2);

        // Mode change mid-frame: the mode 10 beat is dropped
        send_beat(1, 0, 2'b01, 0, 32'h0001_0002, 32'h0010_0020);
        send_beat(0, 0, 2'b10, 0, 32'hFFFF_FFFF, 32'h0);
        send_beat(0, 1, 2'b01, 0, 32'h0100_0200, 32'h0);
        tick();
        expect_out("mchg", 64'h0000_0111_0000_0222, 2'b01, 4'd0, 1'b1, 8'd2);

        // Orphan non-first beat opens a frame with err
        send_beat(0, 1, 2'b00, 0, 32'd7, 32'd0);
        tick();
        expect_out("orphan", 64'd7, 2'b00, 4'd0, 1'b1, 8'd1);

        // Signed clamp both directions, count saturation
        for (int i = 0; i < 300; i++)
            send_beat(i == 0, i == 299, 2'b10, 1, 32'h0000_7F80, 32'h0);
        tick();
        expect_out("sat_s", 64'h0000_0000_7FFF_8000, 2'b10, 4'b0011, 1'b0, 8'd255);

        // Unsigned carry-out clamp
        for (int i = 0; i < 260; i++)
            send_beat(i == 0, i == 259, 2'b10, 0, 32'h0000_00F0, 32'h0000_000F);
        tick();
        expect_out("sat_u", 64'h0000_0000_0000_FFFF, 2'b10, 4'b0001, 1'b0, 8'd255);

        // Back-to-back single-beat frames with no bubble
        send_beat(1, 1, 2'b00, 0, 32'h11, 32'h0);
        send_beat(1, 1, 2'b00, 0, 32'h22, 32'h0);
        expect_out("b2b_a", 64'h11, 2'b00, 4'd0, 1'b0, 8'd1);
        tick();
        expect_out("b2b_b", 64'h22, 2'b00, 4'd0, 1'b0, 8'd1);
        tick();

        // Output back-pressure with in_valid held high
        out_ready = 1'b0;
        send_beat(1, 1, 2'b00, 0, 32'hA, 32'h0);
        send_beat(1, 1, 2'b00, 0, 32'hB, 32'h0);
        in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; mode = 2'b00; in_signed = 1'b0;
        result_0 = 32'hC; result_1 = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_out_acc", out_acc, 64'hA);
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            tick();
        end
        out_ready = 1'b1;
        send_beat(1, 1, 2'b00, 0, 32'hC, 32'h0);
        expect_out("bp_b", 64'hB, 2'b00, 4'd0, 1'b0, 8'd1);
        tick();
        expect_out("bp_c", 64'hC, 2'b00, 4'd0, 1'b0, 8'd1);
        tick();

        // Reset mid-frame discards the partial sum
        send_beat(1, 0, 2'b00, 0, 32'd100, 32'd0);
        send_beat(0, 0, 2'b00, 0, 32'd200, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        tick();
        reset = 1'b0;
        chk("midrst_ready_hold", 64'(in_ready), 64'd0);
        send_beat(1, 1, 2'b00, 0, 32'd2, 32'd3);
        tick();
        expect_out("after_rst", 64'd5, 2'b00, 4'd0, 1'b0, 8'd1);
        repeat (3) tick();

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
